vend_multi_ctrl: RTL and testbench
==================================

Name: vend_multi_ctrl

Overview:
Parametrised multi-product vending controller and the successor to the single-price demo08 machine. It accepts 0.5-yuan and 1-yuan coin pulses into a saturating credit register and serves one of N_PROD products, each with its own price. It supports cancel/refund and returns change serially, one coin per cycle. It sits between the coin acceptor front end and the dispenser/change-hopper drivers.

Parameters:
N_PROD, 2, number of products (1..8)
CREDIT_W, 6, credit register width; all money in half-yuan units
PRICE_VEC, {6'd6, 6'd4}, packed N_PROD*CREDIT_W vector; slot i is the price of product i (default: P0=2.0 yuan, P1=3.0 yuan)
MAX_CREDIT, 20, credit ceiling in half-yuan units (10 yuan); must be < 2**CREDIT_W
TIMEOUT, 1000, idle cycles before auto-refund (used only with VEND_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
coin_05  in  1  one-cycle pulse, 0.5 yuan inserted
coin_1  in  1  one-cycle pulse, 1 yuan inserted
sel  in  N_PROD  one-cycle product-select pulse, one bit per product
cancel  in  1  one-cycle refund request
dispense  out  1  one-cycle pulse, product released
dispense_id  out  IDW  index of the dispensed product; IDW = max(1, clog2(N_PROD))
change_05  out  1  one-cycle pulse, return one 0.5-yuan coin
change_1  out  1  one-cycle pulse, return one 1-yuan coin
coin_reject  out  1  one-cycle pulse, the inserted coin was not credited and is returned by the mechanism
deny  out  1  one-cycle pulse, select received with insufficient credit
busy  out  1  high in CHANGE state
credit  out  CREDIT_W  current credit in half-yuan units

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, credit=0, every output 0. This takes effect immediately, including mid-CHANGE; any pending change is discarded.
- All outputs are registered. An input sampled at edge k produces its effect in the cycle after edge k.
- States:
  - IDLE: credit==0.
  - COLLECT: credit>0 and accepting coins.
  - CHANGE: paying out change.
- Coin value: coin_05=1, coin_1=2. Both pulses in the same cycle add 3.
- Coin handling in IDLE/COLLECT:
  - If credit+value <= MAX_CREDIT: credit += value, and IDLE moves to COLLECT.
  - Otherwise: the whole value is rejected (coin_reject=1) and credit is unchanged.
- Coins in CHANGE: always rejected (coin_reject=1).
- Select in COLLECT (pre-coin credit is used):
  - Multiple sel bits set: the lowest index wins.
  - credit >= price[i]: dispense=1, dispense_id=i, credit -= price[i]. Next state is CHANGE if the remainder is >0, else IDLE.
  - credit < price[i]: deny=1; credit and state unchanged.
- Select in IDLE gives deny=1. Select in CHANGE is ignored.
- Cancel in COLLECT moves to CHANGE with the full credit. Cancel in IDLE/CHANGE is ignored. Cancel and sel in the same cycle: cancel wins, sel is ignored.
- A coin arriving in the same cycle as an accepted sel or cancel is rejected (coin_reject=1).
- CHANGE: one pulse per cycle, starting the cycle after entry.
  - credit>=2: change_1=1, credit -= 2.
  - credit==1: change_05=1, credit -= 1.
  - credit reaches 0: return to IDLE.
- Arithmetic is unsigned CREDIT_W-bit. Credit never exceeds MAX_CREDIT and never wraps.

Optional Feature:
VEND_TIMEOUT_EN
- Defined: a counter runs while in COLLECT and clears on any coin, sel or cancel. When it reaches TIMEOUT, the block behaves as an implicit cancel (moves to CHANGE with the full credit).
- Undefined: no counter is built and credit is held indefinitely.

Decomposition:
- vend_pkg holds:
  - state enum {IDLE, COLLECT, CHANGE}
  - COIN_05_VAL=1, COIN_1_VAL=2
  - a helper function extracting price i from PRICE_VEC
- Sub-module vend_change_gen: takes a load value, emits change_1/change_05 pulses and a done signal. The top-level FSM owns the credit register and priority logic.

Test Plan:
- Reset, 1+1, sel[0] -> credit 4, dispense=1 with id=0 for one cycle, no change pulses, credit 0, IDLE.
- 1+1+0.5, sel[0] -> dispense id=0, then exactly one change_05 pulse, busy high for 1 cycle, credit 0.
- 1+1+1+1, sel[1] -> dispense id=1, credit 2, then one change_1 pulse, IDLE.
- 0.5+1, sel[1] -> deny=1, credit stays 3; cancel -> change_1 then change_05 on consecutive cycles, credit 0.
- Ten coin_1 (credit 20), eleventh coin_1 -> coin_reject=1, credit 20; sel[0] together with coin_05 -> coin rejected, dispense, 8 change_1 pulses; coin_1 during CHANGE -> coin_reject.
- reset=0 mid-CHANGE -> all outputs and credit 0 immediately. With VEND_TIMEOUT_EN and TIMEOUT=5: insert 0.5 and wait -> change_05 pulse after 5 idle cycles.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product vending controller.
// Money is always counted in half-yuan units.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHANGE  = 2'd2
    } vend_state_e;

    localparam int COIN_05_VAL = 1;
    localparam int COIN_1_VAL  = 2;

    // Price vectors are zero-extended to 128 bits (8 products x 16 bits max).
    function automatic logic [15:0] price_at(input logic [127:0] vec,
                                             input int unsigned idx,
                                             input int unsigned w);
        logic [127:0] sh;
        logic [127:0] mask;
        sh   = vec >> (idx * w);
        mask = (128'd1 << w) - 128'd1;
        return 16'(sh & mask);
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Change payout generator: picks the largest coin that fits the amount still
// owed, registers the coin pulse, and flags the last coin of the payout.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                active,
    input  logic [CREDIT_W-1:0] amount,
    output logic [CREDIT_W-1:0] step,
    output logic                last,
    output logic                change_1,
    output logic                change_05
);

    logic change_1_d, change_1_q;
    logic change_05_d, change_05_q;

    always_comb begin
        step        = '0;
        change_1_d  = 1'b0;
        change_05_d = 1'b0;
        if (active) begin
            if (amount >= CREDIT_W'(COIN_1_VAL)) begin
                step       = CREDIT_W'(COIN_1_VAL);
                change_1_d = 1'b1;
            end else if (amount != '0) begin
                step        = CREDIT_W'(COIN_05_VAL);
                change_05_d = 1'b1;
            end
        end
        last = active && (amount == step);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            change_1_q  <= 1'b0;
            change_05_q <= 1'b0;
        end else begin
            change_1_q  <= change_1_d;
            change_05_q <= change_05_d;
        end
    end

    assign change_1  = change_1_q;
    assign change_05 = change_05_q;

endmodule

// File: rtl/vend_multi_ctrl.sv
// Multi-product vending controller: credit register, select/cancel priority and
// change payout. Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT idle cycles.
//
// state   | meaning
// IDLE    | credit is zero
// COLLECT | credit > 0, accepting coins, select and cancel
// CHANGE  | paying out remaining credit one coin per cycle
module vend_multi_ctrl
    import vend_pkg::*;
#(
    parameter int                          N_PROD     = 2,
    parameter int                          CREDIT_W   = 6,
    parameter logic [N_PROD*CREDIT_W-1:0]  PRICE_VEC  = {6'd6, 6'd4},
    parameter int                          MAX_CREDIT = 20,
    parameter int                          TIMEOUT    = 1000,
    localparam int                         IDW        = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_05,
    input  logic                coin_1,
    input  logic [N_PROD-1:0]   sel,
    input  logic                cancel,
    output logic                dispense,
    output logic [IDW-1:0]      dispense_id,
    output logic                change_05,
    output logic                change_1,
    output logic                coin_reject,
    output logic                deny,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [127:0] PRICE_VEC_X = 128'(PRICE_VEC);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic [IDW-1:0]      dispense_id_q, dispense_id_d;
    logic                coin_reject_q, coin_reject_d;
    logic                deny_q, deny_d;
    logic                busy_q, busy_d;

    logic                coin_any;
    logic                sel_any;
    logic [IDW-1:0]      sel_idx;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                timeout_hit;
    logic                chg_active;
    logic [CREDIT_W-1:0] chg_step;
    logic                chg_last;

    always_comb begin
        sel_idx = '0;
        for (int i = N_PROD - 1; i >= 0; i--) begin
            if (sel[i]) sel_idx = IDW'(i);
        end
        sel_any   = |sel;
        price     = CREDIT_W'(price_at(PRICE_VEC_X, 32'(sel_idx), CREDIT_W));
        coin_any  = coin_05 | coin_1;
        coin_val  = (coin_05 ? CREDIT_W'(COIN_05_VAL) : '0) +
                    (coin_1  ? CREDIT_W'(COIN_1_VAL)  : '0);
        coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
        coin_fits = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          activity;

    // Down-counter reloads on any activity or outside COLLECT; terminal count is 1.
    always_comb begin
        activity = coin_any | sel_any | cancel;
        tmr_d    = tmr_q;
        if (state_q != COLLECT || activity) begin
            tmr_d = TW'(TIMEOUT);
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TW'(1);
        end
        timeout_hit = (state_q == COLLECT) && !activity && (tmr_q == TW'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmr_q <= TW'(TIMEOUT);
        else        tmr_q <= tmr_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign chg_active = (state_q == CHANGE);

    vend_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .clk       (clk),
        .reset     (reset),
        .active    (chg_active),
        .amount    (credit_q),
        .step      (chg_step),
        .last      (chg_last),
        .change_1  (change_1),
        .change_05 (change_05)
    );

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        dispense_d    = 1'b0;
        dispense_id_d = '0;
        coin_reject_d = 1'b0;
        deny_d        = 1'b0;
        unique case (state_q)
            IDLE, COLLECT: begin
                if (state_q == COLLECT && (cancel || timeout_hit)) begin
                    state_d       = CHANGE;
                    coin_reject_d = coin_any;
                end else if (state_q == COLLECT && sel_any && credit_q >= price) begin
                    dispense_d    = 1'b1;
                    dispense_id_d = sel_idx;
                    credit_d      = credit_q - price;
                    state_d       = (credit_q == price) ? IDLE : CHANGE;
                    coin_reject_d = coin_any;
                end else begin
                    // A denied select does not block coins arriving with it.
                    deny_d = sel_any;
                    if (coin_any) begin
                        if (coin_fits) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                            state_d  = COLLECT;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                end
            end
            CHANGE: begin
                coin_reject_d = coin_any;
                credit_d      = credit_q - chg_step;
                if (chg_last) state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
        busy_d = (state_d == CHANGE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            dispense_q    <= 1'b0;
            dispense_id_q <= '0;
            coin_reject_q <= 1'b0;
            deny_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            dispense_q    <= dispense_d;
            dispense_id_q <= dispense_id_d;
            coin_reject_q <= coin_reject_d;
            deny_q        <= deny_d;
            busy_q        <= busy_d;
        end
    end

    assign credit      = credit_q;
    assign dispense    = dispense_q;
    assign dispense_id = dispense_id_q;
    assign coin_reject = coin_reject_q;
    assign deny        = deny_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_multi_ctrl.sv
// Self-checking bench for vend_multi_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural model of the vending rules.
module tb_vend_multi_ctrl;

    localparam int TMO  = 5;
    localparam int MAXC = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin_05 = 1'b0, coin_1 = 1'b0, cancel = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       dispense, change_05, change_1, coin_reject, deny, busy;
    logic [0:0] dispense_id;
    logic [5:0] credit;

    int checks = 0;
    int errors = 0;

    int price [2] = '{4, 6};

    int m_credit;
    bit m_pay;
    int m_idle;
    bit e_disp, e_deny, e_rej, e_c1, e_c05, e_busy;
    int e_id, e_credit;

    vend_multi_ctrl #(
        .N_PROD     (2),
        .CREDIT_W   (6),
        .PRICE_VEC  ({6'd6, 6'd4}),
        .MAX_CREDIT (MAXC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_05     (coin_05),
        .coin_1      (coin_1),
        .sel         (sel),
        .cancel      (cancel),
        .dispense    (dispense),
        .dispense_id (dispense_id),
        .change_05   (change_05),
        .change_1    (change_1),
        .coin_reject (coin_reject),
        .deny        (deny),
        .busy        (busy),
        .credit      (credit)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_credit = 0;
        m_pay    = 0;
        m_idle   = 0;
    endtask

    // Drive one cycle of inputs, advance the model, and land at posedge+1.
    task automatic cyc(input bit c05, input bit c1, input logic [1:0] s, input bit cn);
        int  val;
        int  idx;
        bit  acc;
        coin_05 = c05; coin_1 = c1; sel = s; cancel = cn;
        val = (c05 ? 1 : 0) + (c1 ? 2 : 0);
        e_disp = 0; e_deny = 0; e_rej = 0; e_c1 = 0; e_c05 = 0; e_id = 0;
        if (m_pay) begin
            e_rej = (val > 0);
            if (m_credit >= 2) begin e_c1 = 1; m_credit -= 2; end
            else begin e_c05 = 1; m_credit -= 1; end
            if (m_credit == 0) m_pay = 0;
            m_idle = 0;
        end else begin
            acc = 0;
`ifdef VEND_TIMEOUT_EN
            if (m_credit > 0 && val == 0 && s == 0 && !cn) begin
                m_idle++;
                if (m_idle == TMO) begin m_pay = 1; acc = 1; m_idle = 0; end
            end else begin
                m_idle = 0;
            end
`endif
            if (m_credit > 0 && cn) begin
                m_pay = 1; acc = 1;
            end else if (s != 0) begin
                idx = s[0] ? 0 : 1;
                if (m_credit > 0 && m_credit >= price[idx]) begin
                    e_disp = 1; e_id = idx;
                    m_credit -= price[idx];
                    m_pay = (m_credit > 0);
                    acc = 1;
                end else begin
                    e_deny = 1;
                end
            end
            if (val > 0) begin
                if (acc || m_credit + val > MAXC) e_rej = 1;
                else m_credit += val;
            end
        end
        e_busy = m_pay;
        e_credit = m_credit;
        @(posedge clk);
        #1;
        coin_05 = 0; coin_1 = 0; sel = 2'b00; cancel = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if ({dispense, change_05, change_1, coin_reject, deny, busy} !== 6'b0 || credit !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs got flags=%b credit=%0d exp all 0",
                     {dispense, change_05, change_1, coin_reject, deny, busy}, credit);
        end
        do_reset();
    endtask

    task automatic test_exact_pay();
        cyc(0, 1, 2'b00, 0);
        cyc(0, 1, 2'b00, 0);
        checks++;
        if (credit !== 6'd4) begin errors++; $display("FAIL exact_credit got %0d exp 4", credit); end
        cyc(0, 0, 2'b01, 0);
        checks++;
        if (dispense !== 1'b1 || dispense_id !== 1'b0 || credit !== 6'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL exact_dispense got disp=%b id=%0d credit=%0d busy=%b exp 1 0 0 0",
                     dispense, dispense_id, credit, busy);
        end
        cyc(0, 0, 2'b00, 0);
        checks++;
        if (dispense !== 1'b0 || change_1 !== 1'b0 || change_05 !== 1'b0) begin
            errors++;
            $display("FAIL exact_after got disp=%b c1=%b c05=%b exp 0 0 0", dispense, change_1, change_05);
        end
    endtask

    task automatic test_change_05();
        int pulses;
        int busy_cycles;
        cyc(0, 1, 2'b00, 0);
        cyc(0, 1, 2'b00, 0);
        cyc(1, 0, 2'b00, 0);
        cyc(0, 0, 2'b01, 0);
        checks++;
        if (dispense !== 1'b1 || dispense_id !== 1'b0 || credit !== 6'd1) begin
            errors++;
            $display("FAIL c05_dispense got disp=%b id=%0d credit=%0d exp 1 0 1", dispense, dispense_id, credit);
        end
        pulses = 0;
        busy_cycles = busy ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 2'b00, 0);
            pulses += change_05;
            busy_cycles += busy;
            if (change_1) pulses += 10;
        end
        checks++;
        if (pulses !== 1 || busy_cycles !== 1 || credit !== 6'd0) begin
            errors++;
            $display("FAIL c05_payout got pulses=%0d busy=%0d credit=%0d exp 1 1 0", pulses, busy_cycles, credit);
        end
    endtask

    task automatic test_sel1();
        for (int i = 0; i < 4; i++) cyc(0, 1, 2'b00, 0);
        cyc(0, 0, 2'b10, 0);
        checks++;
        if (dispense !== 1'b1 || dispense_id !== 1'b1 || credit !== 6'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sel1_dispense got disp=%b id=%0d credit=%0d busy=%b exp 1 1 2 1",
                     dispense, dispense_id, credit, busy);
        end
        cyc(0, 0, 2'b00, 0);
        checks++;
        if (change_1 !== 1'b1 || change_05 !== 1'b0 || credit !== 6'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sel1_change got c1=%b c05=%b credit=%0d busy=%b exp 1 0 0 0",
                     change_1, change_05, credit, busy);
        end
    endtask

    task automatic test_deny_cancel();
        cyc(1, 0, 2'b00, 0);
        cyc(0, 1, 2'b00, 0);
        cyc(0, 0, 2'b10, 0);
        checks++;
        if (deny !== 1'b1 || dispense !== 1'b0 || credit !== 6'd3) begin
            errors++;
            $display("FAIL deny got deny=%b disp=%b credit=%0d exp 1 0 3", deny, dispense, credit);
        end
        cyc(0, 0, 2'b01, 1);
        checks++;
        if (busy !== 1'b1 || dispense !== 1'b0 || credit !== 6'd3) begin
            errors++;
            $display("FAIL cancel_entry got busy=%b disp=%b credit=%0d exp 1 0 3", busy, dispense, credit);
        end
        cyc(0, 0, 2'b00, 0);
        checks++;
        if (change_1 !== 1'b1 || change_05 !== 1'b0 || credit !== 6'd1) begin
            errors++;
            $display("FAIL cancel_c1 got c1=%b c05=%b credit=%0d exp 1 0 1", change_1, change_05, credit);
        end
        cyc(0, 0, 2'b00, 0);
        checks++;
        if (change_1 !== 1'b0 || change_05 !== 1'b1 || credit !== 6'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_c05 got c1=%b c05=%b credit=%0d busy=%b exp 0 1 0 0",
                     change_1, change_05, credit, busy);
        end
    endtask

    task automatic test_saturate();
        int pulses;
        for (int i = 0; i < 10; i++) cyc(0, 1, 2'b00, 0);
        cyc(0, 1, 2'b00, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 6'd20) begin
            errors++;
            $display("FAIL sat_reject got rej=%b credit=%0d exp 1 20", coin_reject, credit);
        end
        cyc(1, 0, 2'b01, 0);
        checks++;
        if (coin_reject !== 1'b1 || dispense !== 1'b1 || credit !== 6'd16) begin
            errors++;
            $display("FAIL sat_sel_coin got rej=%b disp=%b credit=%0d exp 1 1 16", coin_reject, dispense, credit);
        end
        cyc(0, 1, 2'b00, 0);
        checks++;
        if (coin_reject !== 1'b1 || change_1 !== 1'b1) begin
            errors++;
            $display("FAIL change_coin_reject got rej=%b c1=%b exp 1 1", coin_reject, change_1);
        end
        pulses = 1;
        for (int i = 0; i < 20 && busy; i++) begin
            cyc(0, 0, 2'b00, 0);
            pulses += change_1;
        end
        checks++;
        if (pulses !== 8 || busy !== 1'b0 || credit !== 6'd0) begin
            errors++;
            $display("FAIL sat_payout got pulses=%0d busy=%b credit=%0d exp 8 0 0", pulses, busy, credit);
        end
    endtask

    task automatic test_reset_mid_change();
        for (int i = 0; i < 6; i++) cyc(0, 1, 2'b00, 0);
        cyc(0, 0, 2'b00, 1);
        cyc(0, 0, 2'b00, 0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({dispense, change_05, change_1, coin_reject, deny, busy} !== 6'b0 || credit !== 6'd0) begin
            errors++;
            $display("FAIL midchange_reset got flags=%b credit=%0d exp all 0",
                     {dispense, change_05, change_1, coin_reject, deny, busy}, credit);
        end
        do_reset();
        cyc(0, 0, 2'b00, 0);
        checks++;
        if (change_1 !== 1'b0 || busy !== 1'b0 || credit !== 6'd0) begin
            errors++;
            $display("FAIL midchange_after got c1=%b busy=%b credit=%0d exp 0 0 0", change_1, busy, credit);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        cyc(1, 0, 2'b00, 0);
        seen = 0;
        n = 0;
        for (int i = 1; i <= 12 && !seen; i++) begin
            cyc(0, 0, 2'b00, 0);
            if (change_05) begin seen = 1; n = i; end
        end
`ifdef VEND_TIMEOUT_EN
        checks++;
        if (!seen || n != TMO + 1 || credit !== 6'd0) begin
            errors++;
            $display("FAIL timeout_refund got seen=%b cycle=%0d credit=%0d exp 1 %0d 0", seen, n, credit, TMO + 1);
        end
`else
        checks++;
        if (seen || credit !== 6'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold got seen=%b credit=%0d busy=%b exp 0 1 0", seen, credit, busy);
        end
        cyc(0, 0, 2'b00, 1);
        cyc(0, 0, 2'b00, 0);
`endif
    endtask

    task automatic test_random();
        bit c05, c1, cn;
        logic [1:0] s;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            c05 = ($urandom_range(0, 99) < 25);
            c1  = ($urandom_range(0, 99) < 25);
            s   = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
            cn  = ($urandom_range(0, 99) < 5);
            cyc(c05, c1, s, cn);
            checks++;
            if (dispense !== e_disp) begin errors++; $display("FAIL rnd_dispense cyc %0d got %b exp %b", k, dispense, e_disp); end
            if (e_disp) begin
                checks++;
                if (dispense_id !== 1'(e_id)) begin errors++; $display("FAIL rnd_id cyc %0d got %0d exp %0d", k, dispense_id, e_id); end
            end
            checks++;
            if (deny !== e_deny) begin errors++; $display("FAIL rnd_deny cyc %0d got %b exp %b", k, deny, e_deny); end
            checks++;
            if (coin_reject !== e_rej) begin errors++; $display("FAIL rnd_reject cyc %0d got %b exp %b", k, coin_reject, e_rej); end
            checks++;
            if (change_1 !== e_c1 || change_05 !== e_c05) begin
                errors++;
                $display("FAIL rnd_change cyc %0d got c1=%b c05=%b exp %b %b", k, change_1, change_05, e_c1, e_c05);
            end
            checks++;
            if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", k, busy, e_busy); end
            checks++;
            if (credit !== 6'(e_credit)) begin errors++; $display("FAIL rnd_credit cyc %0d got %0d exp %0d", k, credit, e_credit); end
        end
    endtask

    initial begin
        test_reset();
        test_exact_pay();
        test_change_05();
        test_sel1();
        test_deny_cancel();
        test_saturate();
        test_reset_mid_change();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
